pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
- Parametrised, elastic successor to the fixed-bundle inter-stage pipeline register.
- Carries one opaque DATA_W-bit stage bundle (control, PC, operands, immediates, dest) between pipeline stages, e.g. ID->EX.
- Adds valid/ready handshaking and a one-entry skid buffer, so back-pressure from the downstream stage never drops an instruction.
- Keeps the hazard-unit freeze and branch flush controls; a flushed or empty stage presents an all-zero bubble.

Parameters:
- DATA_W, 147, width of the stage bundle (ID->EX bundle size).
- CNT_W, 2, width of the occupancy output (must be >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
- flush  input  1  discard all held entries (branch taken).
- freeze  input  1  hazard stall; no transfer on either side.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  DATA_W  incoming stage bundle.
- out_valid  output  1  out_data holds a live instruction.
- out_ready  input  1  downstream consumes this cycle.
- out_data  output  DATA_W  stage bundle to the next stage; all-zero when out_valid=0.
- occupancy  output  CNT_W  number of held entries, 0..2.

Behaviour:
- Storage:
  - main register: main_valid, main_data; drives the outputs.
  - skid register: skid_valid, skid_data.
- States: EMPTY (main=0, skid=0), ONE (main=1, skid=0), FULL (main=1, skid=1). main=0 with skid=1 is illegal and never reached.
- Reset (rst=0 at clk edge): main_valid=0, skid_valid=0, main_data=0, skid_data=0. Hence out_valid=0, out_data=0, in_ready=0 during reset, occupancy=0. Reset overrides flush, freeze and all handshakes.
- Combinational outputs:
  - in_ready = rst & ~skid_valid & ~freeze & ~flush.
  - out_valid = main_valid.
  - out_data = main_data.
  - occupancy = main_valid + skid_valid.
- Transfer definitions:
  - acc = in_valid & in_ready.
  - con = main_valid & out_ready & ~freeze & ~flush.
- Flush (rst=1, flush=1): next cycle is EMPTY with both data registers zeroed. The input offered that cycle is not accepted (in_ready=0). Flush has priority over freeze.
- Freeze (flush=0): all registers hold. out_valid/out_data stay stable even if out_ready=1; in_ready=0.
- EMPTY:
  - acc -> ONE, main_data<=in_data.
  - otherwise stay.
- ONE:
  - acc & con -> ONE, main_data<=in_data (back-to-back, full throughput).
  - acc & ~con -> FULL, skid_data<=in_data.
  - con & ~acc -> EMPTY, main_data<=0.
  - neither -> hold.
- FULL:
  - in_ready=0.
  - con -> ONE, main_data<=skid_data, skid_data<=0.
  - else hold.
- Latency: 1 cycle from accept to out_valid when EMPTY or consuming. Throughput is 1 per cycle while out_ready=1 and freeze=0.
- Ordering is strictly FIFO; no entry is duplicated or lost except by flush or reset.
- Data registers change only as listed above. No X propagates from in_data when acc=0.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 and in_data=all-ones -> out_valid=0, out_data=0, occupancy=0, in_ready=0 throughout. First cycle after rst=1 -> in_ready=1.
- Streaming: out_ready=1, send A=0x1, B=0x2, C=0x3 on consecutive cycles -> out_data shows 0x1, 0x2, 0x3 on the following 3 cycles, out_valid=1 each, occupancy stays 1.
- Back-pressure:
  - Send 0x10, then 0x11, with out_ready=0 -> occupancy=2, in_ready=0, out_data=0x10.
  - Raise out_ready -> 0x10 consumed, out_data=0x11 next cycle, occupancy=1, in_ready=1.
- Freeze: FULL with 0x20/0x21, freeze=1 and out_ready=1 for 3 cycles -> out_data holds 0x20, occupancy=2. On release -> 0x20, 0x21 delivered in order.
- Flush priority: FULL state, assert flush with in_valid=1 (data 0x30) and freeze=1 -> next cycle occupancy=0, out_valid=0, out_data=0, and 0x30 never appears.
- Reset mid-operation: occupancy=2, drive rst=0 for one edge -> EMPTY and zeroed. A subsequent send of 0x40 appears 1 cycle after accept.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - elastic inter-stage pipeline register with one-entry skid buffer
module pipe_stage_skid_reg #(
    parameter int DATA_W = 147,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] main_data, main_data_n;
    logic [DATA_W-1:0] skid_data, skid_data_n;
    logic              main_valid, skid_valid;
    logic              acc, con;

    assign main_valid = (state != EMPTY);
    assign skid_valid = (state == FULL);

    assign in_ready  = rst & ~skid_valid & ~freeze & ~flush;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = CNT_W'(main_valid) + CNT_W'(skid_valid);

    // Freeze and flush gate both transfers, so the hold case needs no extra branch.
    assign acc = in_valid & in_ready;
    assign con = main_valid & out_ready & ~freeze & ~flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= EMPTY;
            main_data <= '0;
            skid_data <= '0;
        end else begin
            state     <= state_n;
            main_data <= main_data_n;
            skid_data <= skid_data_n;
        end
    end

    always_comb begin
        state_n     = state;
        main_data_n = main_data;
        skid_data_n = skid_data;
        if (flush) begin
            state_n     = EMPTY;
            main_data_n = '0;
            skid_data_n = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state_n     = ONE;
                        main_data_n = in_data;
                    end
                end
                ONE: begin
                    if (acc && con) begin
                        main_data_n = in_data;
                    end else if (acc) begin
                        state_n     = FULL;
                        skid_data_n = in_data;
                    end else if (con) begin
                        state_n     = EMPTY;
                        main_data_n = '0;
                    end
                end
                FULL: begin
                    if (con) begin
                        state_n     = ONE;
                        main_data_n = skid_data;
                        skid_data_n = '0;
                    end
                end
                default: begin
                    state_n     = EMPTY;
                    main_data_n = '0;
                    skid_data_n = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - randomized self-checking bench for pipe_stage_skid_reg
module tb_pipe_stage_skid_reg;

    localparam int DATA_W = 147;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              freeze;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  occupancy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] model_q[$];

    pipe_stage_skid_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .freeze    (freeze),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < 5; i++) d = {d[DATA_W-33:0], 32'($urandom)};
        return d;
    endfunction

    // Drive one cycle of inputs, compare outputs against the queue model, then advance the model.
    task automatic cycle(input logic r, input logic fl, input logic fz, input logic iv,
                         input logic [DATA_W-1:0] d, input logic ordy);
        int  sz;
        logic exp_rdy;
        rst = r; flush = fl; freeze = fz; in_valid = iv; in_data = d; out_ready = ordy;
        sz = model_q.size();
        exp_rdy = r && !fl && !fz && (sz < 2);
        @(negedge clk);
        check_eq("in_ready",  DATA_W'(in_ready),  DATA_W'(exp_rdy));
        check_eq("out_valid", DATA_W'(out_valid), DATA_W'(sz > 0));
        check_eq("out_data",  out_data, (sz > 0) ? model_q[0] : '0);
        check_eq("occupancy", DATA_W'(occupancy), DATA_W'(sz));
        @(posedge clk);
        if (!r || fl) begin
            model_q.delete();
        end else if (!fz) begin
            if (sz > 0 && ordy) void'(model_q.pop_front());
            if (iv && sz < 2) model_q.push_back(d);
        end
        #1;
    endtask

    initial begin
        logic [DATA_W-1:0] ones;
        ones = '1;
        rst = 1'b0; flush = 1'b0; freeze = 1'b0; in_valid = 1'b1; in_data = ones; out_ready = 1'b0;
        @(posedge clk);
        #1;

        cycle(0, 0, 0, 1, ones, 0);
        cycle(0, 0, 0, 1, ones, 1);

        // streaming
        cycle(1, 0, 0, 1, DATA_W'(1), 1);
        cycle(1, 0, 0, 1, DATA_W'(2), 1);
        cycle(1, 0, 0, 1, DATA_W'(3), 1);
        cycle(1, 0, 0, 0, '0, 1);
        cycle(1, 0, 0, 0, '0, 1);
        cycle(1, 0, 0, 0, '0, 1);

        // back-pressure
        cycle(1, 0, 0, 1, DATA_W'(16), 0);
        cycle(1, 0, 0, 1, DATA_W'(17), 0);
        cycle(1, 0, 0, 1, DATA_W'(99), 0);
        cycle(1, 0, 0, 0, '0, 1);
        cycle(1, 0, 0, 0, '0, 1);
        cycle(1, 0, 0, 0, '0, 1);

        // freeze while full
        cycle(1, 0, 0, 1, DATA_W'(32), 0);
        cycle(1, 0, 0, 1, DATA_W'(33), 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 1, DATA_W'(34), 1);
        cycle(1, 0, 0, 0, '0, 1);
        cycle(1, 0, 0, 0, '0, 1);
        cycle(1, 0, 0, 0, '0, 1);

        // flush beats freeze and drops the offered input
        cycle(1, 0, 0, 1, DATA_W'(36), 0);
        cycle(1, 0, 0, 1, DATA_W'(37), 0);
        cycle(1, 1, 1, 1, DATA_W'(48), 1);
        cycle(1, 0, 0, 0, '0, 1);

        // reset mid-operation
        cycle(1, 0, 0, 1, DATA_W'(50), 0);
        cycle(1, 0, 0, 1, DATA_W'(51), 0);
        cycle(0, 0, 0, 1, DATA_W'(52), 1);
        cycle(1, 0, 0, 1, DATA_W'(64), 0);
        cycle(1, 0, 0, 0, '0, 1);
        cycle(1, 0, 0, 0, '0, 1);

        for (int n = 0; n < 3000; n++) begin
            logic r, fl, fz, iv, ordy;
            r    = ($urandom_range(99) >= 2);
            fl   = ($urandom_range(99) < 5);
            fz   = ($urandom_range(99) < 12);
            iv   = ($urandom_range(99) < 65);
            ordy = ($urandom_range(99) < 55);
            cycle(r, fl, fz, iv, rand_data(), ordy);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
